uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among N_REQ byte producers (ALU result path, status/echo path, debug).
- Round-robin arbitration with one byte in flight at a time.
- Drives the transmitter's tx_start/din, and tracks its tx_done_tick to release the grant.
- Sits between the producers and the UART TX instance, on the same clk/reset domain as the baud tick generator.

Parameters:
- N_REQ, 4, number of requesters (>=1).
- DBIT, 8, data width per byte; must match the transmitter's DBIT.
- IDX_W, 2, owner index width = clog2(N_REQ), minimum 1.
- TIMEOUT_CYCLES, 65536, clk cycles allowed in WAIT before abort (used only with UART_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level; bit i high = requester i has a byte.
- req_data  in  N_REQ*DBIT  flattened bytes; requester i uses bits [i*DBIT +: DBIT].
- gnt  out  N_REQ  one-hot, 1-cycle pulse: byte of requester i captured.
- done  out  N_REQ  one-hot, 1-cycle pulse: byte of requester i fully sent (stop bit complete).
- busy  out  1  high whenever state != IDLE.
- tx_start  out  1  1-cycle start pulse to the transmitter.
- tx_din  out  DBIT  byte to the transmitter; stable from LAUNCH until the next capture.
- tx_done_tick  in  1  completion pulse from the transmitter.
- timeout_err  out  1  1-cycle pulse on watchdog abort; tied 0 when the feature is absent.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high): state=IDLE, gnt=0, done=0, tx_start=0, tx_din=0, busy=0, timeout_err=0, last_owner=N_REQ-1 (requester 0 has first priority), owner=0, watchdog counter=0.
- Reset mid-transfer abandons the byte with no done pulse. The transmitter shares reset, so both return to idle together.

State machine:
- IDLE:
  - If any req bit is set, select the first set bit scanning from (last_owner+1) mod N_REQ upward with wrap-around.
  - Latch owner, load tx_din from that requester's slice, pulse gnt[owner], go to LAUNCH.
  - If no req bit is set, stay in IDLE.
- LAUNCH: tx_start=1 for exactly this cycle; clear watchdog; go to WAIT.
- WAIT:
  - On tx_done_tick: pulse done[owner], set last_owner=owner, go to IDLE.
  - Otherwise hold.
- tx_done_tick is ignored in IDLE and LAUNCH.

Latency:
- req sampled high in IDLE at edge k: gnt and busy high after edge k+1; tx_start high after edge k+2.
- tx_done_tick at edge m: done after edge m+1. Next grant can be issued at the earliest after edge m+2 (one IDLE cycle between bytes).

Handshake and fairness:
- Data is captured only in the IDLE->LAUNCH transition. req_data and req may change freely after gnt without affecting the byte in flight.
- A requester holding req high after done is re-eligible, but only after all other pending requesters have been served.
- With N_REQ=1, back-to-back grants to requester 0 occur with one IDLE cycle between them.

Invariants:
- gnt, done, tx_start and timeout_err are mutually exclusive in any cycle.
- At most one bit of gnt or done is set.
- busy is 0 only in IDLE.

Optional Feature:
- UART_ARB_TIMEOUT_EN defined:
  - A watchdog counter (width clog2(TIMEOUT_CYCLES)) increments every clk in WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without tx_done_tick: pulse timeout_err for 1 cycle, set last_owner=owner, go to IDLE, no done pulse.
  - If tx_done_tick arrives in the same cycle as the terminal count, done wins and timeout_err stays 0.
- UART_ARB_TIMEOUT_EN undefined: no counter is built, timeout_err is tied 0, and WAIT holds indefinitely.

Test Plan:
- Single requester: req=4'b0001, req_data[7:0]=8'hA5 → gnt=0001 one cycle later, tx_start one cycle after that, tx_din=8'hA5; fake tx_done_tick 20 cycles later → done=0001 next cycle, busy falls.
- Round-robin: req=4'b1111 held, bytes 11/22/33/44 → grants in order 0,1,2,3,0, each preceded by a done; tx_din sequence 11,22,33,44,11.
- Data stability: after gnt to requester 2 (byte 8'h3C), change req_data slice to 8'hFF and drop req → tx_din stays 8'h3C until the next grant; requester 2 is not regranted.
- Spurious done: tx_done_tick asserted in IDLE and in the LAUNCH cycle → no done pulse, state progression unchanged.
- Reset mid-WAIT: assert reset for 1 cycle in WAIT with req=4'b0010 still high → all outputs 0, no done; the next grant goes to requester 1 (pointer reset to 3, scan starts at 0, first set bit is 1).
- With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=32, no tx_done_tick → timeout_err pulses exactly 32 cycles after WAIT entry, no done, and the next pending requester is granted.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side bundle for uart_tx_arbiter.
// slave = arbiter view, master = producers + UART TX view.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DBIT  = 8
);
  logic [N_REQ-1:0]      req;
  logic [N_REQ*DBIT-1:0] req_data;
  logic [N_REQ-1:0]      gnt;
  logic [N_REQ-1:0]      done;
  logic                  busy;
  logic                  tx_start;
  logic [DBIT-1:0]       tx_din;
  logic                  tx_done_tick;
  logic                  timeout_err;

  modport slave (
    input  req, req_data, tx_done_tick,
    output gnt, done, busy, tx_start, tx_din, timeout_err
  );

  modport master (
    output req, req_data, tx_done_tick,
    input  gnt, done, busy, tx_start, tx_din, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Optional WAIT watchdog is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DBIT           = 8,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);

  if (N_REQ < 1 || IDX_W < 1 || TIMEOUT_CYCLES < 2 || (2 ** IDX_W) < N_REQ) begin : g_cfg_err
    $error("uart_tx_arbiter: inconsistent parameter set");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  owner, owner_n;
  logic [IDX_W-1:0]  last_owner, last_owner_n;
  logic [IDX_W-1:0]  sel, cand;
  logic              found;
  logic [DBIT-1:0]   din, din_n;
  logic [N_REQ-1:0]  gnt, gnt_n;
  logic [N_REQ-1:0]  done, done_n;
  logic              busy, busy_n;
  logic              start, start_n;
  logic              terr, terr_n;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]  wdog, wdog_n;
`endif

  // Round-robin scan: first pending request after last_owner, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_owner) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    din_n        = din;
    gnt_n        = '0;
    done_n       = '0;
    start_n      = 1'b0;
    terr_n       = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    wdog_n       = wdog;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          owner_n = sel;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (sel == IDX_W'(i)) din_n = bus.req_data[i*DBIT +: DBIT];
          end
          gnt_n   = N_REQ'(1) << sel;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        start_n = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
        wdog_n  = '0;
`endif
        state_n = WAIT;
      end
      WAIT: begin
        // A completion arriving on the terminal count takes precedence.
        if (bus.tx_done_tick) begin
          done_n       = N_REQ'(1) << owner;
          last_owner_n = owner;
          state_n      = IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wdog == TERM) begin
          terr_n       = 1'b1;
          last_owner_n = owner;
          state_n      = IDLE;
        end else begin
          wdog_n = wdog + CNT_W'(1);
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(N_REQ - 1);
      din        <= '0;
      gnt        <= '0;
      done       <= '0;
      busy       <= 1'b0;
      start      <= 1'b0;
      terr       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      wdog       <= '0;
`endif
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      din        <= din_n;
      gnt        <= gnt_n;
      done       <= done_n;
      busy       <= busy_n;
      start      <= start_n;
      terr       <= terr_n;
`ifdef UART_ARB_TIMEOUT_EN
      wdog       <= wdog_n;
`endif
    end
  end

  assign bus.gnt         = gnt;
  assign bus.done        = done;
  assign bus.busy        = busy;
  assign bus.tx_start    = start;
  assign bus.tx_din      = din;
  assign bus.timeout_err = terr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus pushes expected
// gnt/tx_start/done/timeout events; a negedge monitor pops and compares them.
module tb_uart_tx_arbiter;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned DBIT  = 8;
  localparam int          TO    = 32;
  localparam int K_GNT = 0, K_START = 1, K_DONE = 2, K_TERR = 3;

  typedef struct {
    int         kind;
    logic [3:0] vec;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .DBIT(DBIT)) bus ();

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .DBIT(DBIT), .IDX_W(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  ev_t exp_q[$];
  int  cyc = 0;
  int  start_cyc = 0;
  int  act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic void push(int kind, int idx, logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.vec  = (kind == K_GNT || kind == K_DONE) ? 4'(1 << idx) : 4'b0000;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  function automatic void observe(int kind, logic [3:0] vec);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d vec %b, expected no event", kind, vec);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.vec != vec) begin
      n_fail++;
      $display("FAIL event_order: got kind %0d vec %b expected kind %0d vec %b",
               kind, vec, e.kind, e.vec);
    end
    case (kind)
      K_GNT: begin
        chk("gnt_din", int'(bus.tx_din), int'(e.data));
        chk("gnt_busy", int'(bus.busy), 1);
      end
      K_START: begin
        chk("start_din", int'(bus.tx_din), int'(e.data));
        chk("start_busy", int'(bus.busy), 1);
        start_cyc = cyc;
      end
      K_DONE: chk("done_busy", int'(bus.busy), 0);
      default: begin
        chk("terr_delay", cyc - start_cyc, TO);
        chk("terr_busy", int'(bus.busy), 0);
      end
    endcase
  endfunction

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      act = int'(|bus.gnt) + int'(|bus.done) + int'(bus.tx_start) + int'(bus.timeout_err);
      if (act != 0) chk("exclusive", act, 1);
      if (|bus.gnt)        observe(K_GNT, bus.gnt);
      if (bus.tx_start)    observe(K_START, 4'b0000);
      if (|bus.done)       observe(K_DONE, bus.done);
      if (bus.timeout_err) observe(K_TERR, 4'b0000);
    end
  end

  task automatic cycle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(int budget);
    int k = 0;
    do begin
      cycle(1);
      k++;
    end while (!bus.tx_start && k < budget);
    chk("start_seen", int'(bus.tx_start), 1);
  endtask

  task automatic send_done(int d);
    cycle(d);
    bus.tx_done_tick = 1'b1;
    cycle(1);
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_gnt"},  int'(bus.gnt), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_start"}, int'(bus.tx_start), 0);
    chk({tag, "_din"},  int'(bus.tx_din), 0);
    chk({tag, "_terr"}, int'(bus.timeout_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.tx_done_tick = 1'b0;
    cycle(2);
    chk_zero("rst");
    reset = 1'b0;

    // Single requester
    bus.req_data = 32'h0000_00A5;
    push(K_GNT, 0, 8'hA5);
    push(K_START, 0, 8'hA5);
    bus.req = 4'b0001;
    wait_start(10);
    bus.req = '0;
    push(K_DONE, 0, 8'h00);
    send_done(20);
    cycle(3);
    chk("s1_idle", int'(bus.busy), 0);

    // Round-robin with all requesters held
    do_reset();
    bus.req_data = 32'h4433_2211;
    for (int i = 0; i < 5; i++) begin
      push(K_GNT, i % 4, 8'(8'h11 * ((i % 4) + 1)));
      push(K_START, 0, 8'(8'h11 * ((i % 4) + 1)));
      push(K_DONE, i % 4, 8'h00);
    end
    bus.req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_start(10);
      send_done(5);
      if (r == 4) bus.req = '0;
    end
    cycle(3);

    // Data stability after capture
    bus.req_data = 32'h003C_0000;
    push(K_GNT, 2, 8'h3C);
    push(K_START, 0, 8'h3C);
    bus.req = 4'b0100;
    cycle(1);
    bus.req_data = 32'h00FF_0000;
    bus.req = '0;
    wait_start(10);
    cycle(4);
    chk("s3_din_hold", int'(bus.tx_din), 8'h3C);
    push(K_DONE, 2, 8'h00);
    send_done(6);
    cycle(4);
    chk("s3_din_after", int'(bus.tx_din), 8'h3C);
    chk("s3_idle", int'(bus.busy), 0);

    // Spurious tx_done_tick in IDLE and in LAUNCH
    bus.tx_done_tick = 1'b1;
    cycle(1);
    bus.tx_done_tick = 1'b0;
    chk("s4_idle_tick", int'(bus.done), 0);
    cycle(1);
    bus.req_data = 32'h0000_5A00;
    push(K_GNT, 1, 8'h5A);
    push(K_START, 0, 8'h5A);
    bus.req = 4'b0010;
    cycle(1);
    bus.tx_done_tick = 1'b1;
    bus.req = '0;
    cycle(1);
    bus.tx_done_tick = 1'b0;
    chk("s4_launch_tick", int'(bus.done), 0);
    chk("s4_start", int'(bus.tx_start), 1);
    cycle(3);
    chk("s4_wait_busy", int'(bus.busy), 1);
    push(K_DONE, 1, 8'h00);
    send_done(4);
    cycle(3);

    // Reset in WAIT with requester 1 still pending
    bus.req_data = 32'h0000_7700;
    push(K_GNT, 1, 8'h77);
    push(K_START, 0, 8'h77);
    bus.req = 4'b0010;
    wait_start(10);
    cycle(2);
    push(K_GNT, 1, 8'h77);
    push(K_START, 0, 8'h77);
    reset = 1'b1;
    cycle(1);
    chk_zero("s5_rst");
    reset = 1'b0;
    wait_start(10);
    bus.req = '0;
    push(K_DONE, 1, 8'h00);
    send_done(5);
    cycle(3);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog abort, then the other pending requester is served
    bus.req_data = 32'h9E00_00C3;
    push(K_GNT, 3, 8'h9E);
    push(K_START, 0, 8'h9E);
    push(K_TERR, 0, 8'h00);
    push(K_GNT, 0, 8'hC3);
    push(K_START, 0, 8'hC3);
    bus.req = 4'b1001;
    wait_start(10);
    bus.req = 4'b0001;
    wait_start(60);
    bus.req = '0;
    push(K_DONE, 0, 8'h00);
    send_done(3);
    cycle(3);
`endif

    cycle(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
